// File: rtl/bs_rbtr_pkg.sv
// rtl/bs_rbtr_pkg.sv - shared types, constants and helpers for the bus arbiter/broadcaster
//   state_t  : IDLE (waiting for a request) / XFER (delivering the latched packet)
//   RR/FIXED : arbitration mode selectors
//   ID_W     : width of the destination ID at the top of each packet
//   get_dest : extracts the destination ID from a packet of a given width
package bs_rbtr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int RR        = 0;
  localparam int FIXED     = 1;
  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 1024;

  // The caller zero-extends its packet to PKT_MAX_W; sz is the real packet width.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                               input int sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction

endpackage

// File: rtl/bs_rbtr_rr_bcast_rr_pick.sv
// rtl/bs_rbtr_rr_bcast_rr_pick.sv - combinational rotating priority encoder
//   req     in  drvrs          request vector
//   ptr     in  clog2(drvrs)   index searched first (ignored in fixed mode)
//   mode    in  1              0 = rotate from ptr, 1 = fixed, index 0 highest
//   gnt_idx out clog2(drvrs)   index of the first request found
//   any     out 1              at least one request present
module rr_pick #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] ptr,
  input  logic                     mode,
  output logic [$clog2(drvrs)-1:0] gnt_idx,
  output logic                     any
);

  localparam int IW = $clog2(drvrs);

  int            start;
  int            idx;
  logic [IW-1:0] idx_s;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    start   = mode ? 0 : int'(ptr);
    idx     = 0;
    idx_s   = '0;
    for (int k = 0; k < drvrs; k++) begin
      // Explicit wrap so non-power-of-two driver counts rotate correctly.
      idx = start + k;
      if (idx >= drvrs) idx = idx - drvrs;
      idx_s = IW'(idx);
      if (!any && req[idx_s]) begin
        any     = 1'b1;
        gnt_idx = idx_s;
      end
    end
  end

endmodule

// File: rtl/bs_rbtr_rr_bcast.sv
// rtl/bs_rbtr_rr_bcast.sv - shared-bus arbiter with unicast/broadcast delivery and drop counting
//   clk      in  1              rising-edge clock
//   reset    in  1              asynchronous active-high reset
//   pndng    in  drvrs          driver FIFO i non-empty
//   D_pop    in  drvrs*pckg_sz  FIFO heads, slice i = driver i
//   pop      out drvrs          pop strobe to the granted driver (combinational, IDLE only)
//   push     out drvrs          push strobes to receivers (registered, XFER cycle)
//   D_push   out drvrs*pckg_sz  receiver data, zero in slices not carrying a packet
//   gnt_id   out clog2(drvrs)   last granted driver
//   busy     out 1              high while in XFER
//   drop     out 1              one-cycle pulse for a discarded packet
//   drop_cnt out cnt_w          saturating count of discarded packets
module bs_rbtr_rr_bcast
  import bs_rbtr_pkg::*;
#(
  parameter int             drvrs     = 4,
  parameter int             pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int             arb_mode  = 0,
  parameter int             cnt_w     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push,
  output logic [$clog2(drvrs)-1:0]   gnt_id,
  output logic                       busy,
  output logic                       drop,
  output logic [cnt_w-1:0]           drop_cnt
);

  localparam int IW = $clog2(drvrs);

  state_t                     state;
  state_t                     state_nxt;
  logic [IW-1:0]              ptr;
  logic [IW-1:0]              w;
  logic                       any;
  logic                       grant;
  logic [pckg_sz-1:0]         pkt;
  logic [ID_W-1:0]            dest;
  logic [drvrs-1:0]           push_nxt;
  logic [drvrs*pckg_sz-1:0]   dpush_nxt;
  logic                       drop_nxt;

  rr_pick #(
    .drvrs (drvrs)
  ) u_pick (
    .req     (pndng),
    .ptr     (ptr),
    .mode    (arb_mode == FIXED),
    .gnt_idx (w),
    .any     (any)
  );

  assign grant = (state == IDLE) && any;

  // Winner's FIFO head; this is the packet latched into the output registers.
  always_comb begin
    pkt = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (w == IW'(i)) pkt = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign dest = get_dest(PKT_MAX_W'(pkt), pckg_sz);

  // Delivery decode, evaluated on the grant cycle so push/D_push/drop come
  // straight out of registers during XFER.
  always_comb begin
    push_nxt  = '0;
    dpush_nxt = '0;
    drop_nxt  = 1'b0;
    if (grant) begin
      if (dest == broadcast) begin
        for (int j = 0; j < drvrs; j++) begin
          push_nxt[j] = (IW'(j) != w);
        end
        dpush_nxt = {drvrs{pkt}};
      end else if ((int'(dest) < drvrs) && (dest != ID_W'(w))) begin
        for (int j = 0; j < drvrs; j++) begin
          if (dest == ID_W'(j)) begin
            push_nxt[j]                      = 1'b1;
            dpush_nxt[j*pckg_sz +: pckg_sz]  = pkt;
          end
        end
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = XFER;
      XFER:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    pop  = '0;
    busy = 1'b0;
    case (state)
      IDLE: begin
        for (int i = 0; i < drvrs; i++) begin
          pop[i] = any && (w == IW'(i));
        end
      end
      XFER:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Registered outputs and arbitration pointer. Outside a grant the *_nxt
  // values are zero, so the XFER->IDLE edge clears push/D_push/drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push     <= '0;
      D_push   <= '0;
      drop     <= 1'b0;
      drop_cnt <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
    end else begin
      push   <= push_nxt;
      D_push <= dpush_nxt;
      drop   <= drop_nxt;
      if (grant) begin
        gnt_id <= w;
        ptr    <= (w == IW'(drvrs - 1)) ? '0 : w + 1'b1;
      end
      if (drop_nxt && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bs_rbtr_rr_bcast.sv
// tb/tb_bs_rbtr_rr_bcast.sv - randomized and directed check of both arbitration modes against a reference model
module tb_bs_rbtr_rr_bcast;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;

  logic [3:0]  pop_rr, push_rr, pop_fp, push_fp;
  logic [63:0] dpush_rr, dpush_fp;
  logic [1:0]  gnt_rr, gnt_fp;
  logic        busy_rr, busy_fp, drop_rr, drop_fp;
  logic [15:0] cnt_rr;
  logic [2:0]  cnt_fp;

  always #5 clk = ~clk;

  bs_rbtr_rr_bcast #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .arb_mode(0), .cnt_w(16)) dut_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_rr), .push(push_rr),
    .D_push(dpush_rr), .gnt_id(gnt_rr), .busy(busy_rr), .drop(drop_rr), .drop_cnt(cnt_rr));

  bs_rbtr_rr_bcast #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .arb_mode(1), .cnt_w(3)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_fp), .push(push_fp),
    .D_push(dpush_fp), .gnt_id(gnt_fp), .busy(busy_fp), .drop(drop_fp), .drop_cnt(cnt_fp));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance.
  // Holds the values the registered outputs take after the most recent clock edge.
  bit          m_busy [2];
  int          m_ptr  [2];
  int          m_gnt  [2];
  int          m_cnt  [2];
  logic [3:0]  m_push [2];
  logic [63:0] m_dp   [2];
  bit          m_drop [2];
  int          m_max  [2] = '{65535, 7};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick(input int i, input logic [3:0] p);
    int base;
    base = (i == 1) ? 0 : m_ptr[i];
    for (int k = 0; k < 4; k++) begin
      if (p[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_pop(input int i, input logic [3:0] p);
    if (!m_busy[i] && p != 4'd0) return 4'b0001 << m_pick(i, p);
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_ptr[i] = 0; m_gnt[i] = 0; m_cnt[i] = 0;
      m_push[i] = '0; m_dp[i] = '0; m_drop[i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] p, input logic [63:0] d);
    int w;
    logic [15:0] pkt;
    int dest;
    for (int i = 0; i < 2; i++) begin
      m_push[i] = '0; m_dp[i] = '0; m_drop[i] = 0;
      if (m_busy[i]) begin
        m_busy[i] = 0;
      end else if (p != 4'd0) begin
        w = m_pick(i, p);
        pkt = d[w*16 +: 16];
        dest = int'(pkt[15:8]);
        m_busy[i] = 1;
        m_gnt[i] = w;
        m_ptr[i] = (w + 1) % 4;
        if (dest == 255) begin
          m_push[i] = 4'hF & ~(4'b0001 << w);
          m_dp[i] = {4{pkt}};
        end else if (dest < 4 && dest != w) begin
          m_push[i] = 4'b0001 << dest;
          m_dp[i][dest*16 +: 16] = pkt;
        end else begin
          m_drop[i] = 1;
          if (m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic check_regs();
    chk("push_rr", push_rr, m_push[0]);   chk("push_fp", push_fp, m_push[1]);
    chk("dpush_rr", dpush_rr, m_dp[0]);   chk("dpush_fp", dpush_fp, m_dp[1]);
    chk("drop_rr", drop_rr, m_drop[0]);   chk("drop_fp", drop_fp, m_drop[1]);
    chk("cnt_rr", cnt_rr, m_cnt[0]);      chk("cnt_fp", cnt_fp, m_cnt[1]);
    chk("gnt_rr", gnt_rr, m_gnt[0]);      chk("gnt_fp", gnt_fp, m_gnt[1]);
    chk("busy_rr", busy_rr, m_busy[0]);   chk("busy_fp", busy_fp, m_busy[1]);
  endtask

  // One clock: check outputs settled from the last edge, drive new inputs,
  // check the combinational pop, then advance the model past the next edge.
  task automatic cycle(input logic [3:0] p, input logic [63:0] d);
    @(negedge clk);
    check_regs();
    pndng = p;
    d_pop = d;
    #1;
    chk("pop_rr", pop_rr, m_pop(0, p));
    chk("pop_fp", pop_fp, m_pop(1, p));
    model_step(p, d);
  endtask

  task automatic reset_now();
    pndng = '0;
    d_pop = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("rst_pop_rr", pop_rr, 4'd0);
    chk("rst_pop_fp", pop_fp, 4'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [15:0] rpkt();
    logic [7:0] dst;
    case ($urandom_range(0, 5))
      0, 1, 2, 3: dst = 8'($urandom_range(0, 3));
      4:          dst = 8'hFF;
      default:    dst = 8'($urandom_range(4, 254));
    endcase
    return {dst, 8'($urandom)};
  endfunction

  logic [63:0] all4;

  initial begin
    reset = 1'b1;
    pndng = '0;
    d_pop = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    reset = 1'b0;

    // All four requesting: RR rotates 0,1,2,3,0; fixed always takes 0.
    all4 = pk(16'h0111, 16'h0022, 16'h0133, 16'h0044);
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, all4);
      chk("rr_pop_order", pop_rr, 4'b0001 << (i % 4));
      chk("fp_pop_fixed", pop_fp, 4'b0001);
      @(posedge clk); #1;
      chk("rr_gnt_order", gnt_rr, i % 4);
      chk("fp_gnt_fixed", gnt_fp, 0);
      cycle(4'hF, all4);
    end

    // Single unicast from driver 1 to receiver 3.
    cycle(4'b0010, pk(16'h0000, 16'h03AB, 16'h0000, 16'h0000));
    chk("uni_pop", pop_rr, 4'b0010);
    @(posedge clk); #1;
    chk("uni_push", push_rr, 4'b1000);
    chk("uni_dpush", dpush_rr, 64'h03AB_0000_0000_0000);
    chk("uni_gnt", gnt_rr, 1);
    cycle(4'b0000, 64'd0);

    // Broadcast from driver 2 excludes itself.
    cycle(4'b0100, pk(16'h0000, 16'h0000, 16'hFF55, 16'h0000));
    @(posedge clk); #1;
    chk("bc_push", push_rr, 4'b1011);
    chk("bc_dpush", dpush_rr, {4{16'hFF55}});
    cycle(4'b0000, 64'd0);

    // Out-of-range destination, then self-address: both dropped.
    cycle(4'b0001, pk(16'h0700, 16'h0000, 16'h0000, 16'h0000));
    @(posedge clk); #1;
    chk("drop7_pulse", drop_rr, 1'b1);
    chk("drop7_push", push_rr, 4'd0);
    cycle(4'b0000, 64'd0);
    cycle(4'b0001, pk(16'h0000, 16'h0000, 16'h0000, 16'h0000));
    @(posedge clk); #1;
    chk("self_pulse", drop_rr, 1'b1);
    chk("self_push", push_rr, 4'd0);
    chk("drop_cnt_rr", cnt_rr, 16'd2);
    chk("drop_cnt_fp", cnt_fp, 3'd2);
    cycle(4'b0000, 64'd0);

    // Reset while delivering: nothing pushed, pointer restarts at driver 0.
    cycle(4'b0010, pk(16'h0000, 16'h0211, 16'h0000, 16'h0000));
    @(posedge clk); #2;
    reset_now();
    cycle(4'hF, all4);
    chk("post_rst_pop", pop_rr, 4'b0001);
    cycle(4'b0000, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            pk(rpkt(), rpkt(), rpkt(), rpkt()));
      if (m_busy[0] && $urandom_range(0, 149) == 0) begin
        @(posedge clk); #2;
        reset_now();
      end
    end
    cycle(4'b0000, 64'd0);
    cycle(4'b0000, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
